receiver_core: RTL and testbench

//  UART receive core. Deserialises one asynchronous serial line into 8-bit bytes.

---
 rtl/receiver_core_pkg.sv | 22 ++
 rtl/receiver_core_rx_sync.sv | 23 ++
 rtl/receiver_core.sv | 130 +++++++++++++
 tb/tb_receiver_core.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/receiver_core_pkg.sv
// receiver_core_pkg: shared state encoding and width helper for the UART receive core
// Contents: state_t (IDLE..STP, 3 bits), clog2() for sizing the bit timer.
package receiver_core_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STRT   = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STP    = 3'd4
   } state_t;

   // Bits needed to hold the values 0..n-1; never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/receiver_core_rx_sync.sv
// receiver_core_rx_sync: 2-FF synchronizer for the serial line plus a one-cycle-delayed copy for edge detection
// Ports: clk, rst (async, active high), rx_i (async line), rx_s_o (synchronized), rx_prev_o (rx_s one cycle earlier).
module receiver_core_rx_sync
   import receiver_core_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rx_i,
   output logic rx_s_o,
   output logic rx_prev_o
);

   // Reset to the idle-high line level so no falling edge is seen out of reset.
   logic [2:0] sr_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) sr_q <= '1;
      else     sr_q <= {sr_q[1:0], rx_i};

   assign rx_s_o    = sr_q[1];
   assign rx_prev_o = sr_q[2];

endmodule

// File: rtl/receiver_core.sv
// receiver_core: UART receiver, 1 start + 8 data (LSB first) + odd parity + 1 stop, one-cycle strobe per byte
// Ports: clk, rst (async, active high), rx (serial in, idles high),
//        data_rx (last byte), data_strobe (1-cycle update pulse), parity_err, frame_err (sticky until next strobe),
//        rx_busy (high outside IDLE).
module receiver_core
   import receiver_core_pkg::*;
#(
   parameter int CLK_RATE  = 100_000_000,
   parameter int BAUD_RATE = 19200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_rx,
   output logic       data_strobe,
   output logic       parity_err,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int BIT_MAX  = CLK_RATE / BAUD_RATE - 1;
   localparam int HALF_MAX = BIT_MAX / 2;
   localparam int TW       = clog2(BIT_MAX + 1);
   localparam logic [TW-1:0] BIT_END  = TW'(BIT_MAX);
   localparam logic [TW-1:0] HALF_END = TW'(HALF_MAX);

   logic rx_s, rx_prev;

   receiver_core_rx_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .rx_i      (rx),
      .rx_s_o    (rx_s),
      .rx_prev_o (rx_prev)
   );

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          par_q, par_d;
   logic          perr_q, perr_d;
   logic [7:0]    data_q, data_d;
   logic          strobe_q, strobe_d;
   logic          parity_err_q, parity_err_d;
   logic          frame_err_q, frame_err_d;

   always_comb begin
      state_d      = state_q;
      timer_d      = (timer_q == BIT_END) ? '0 : timer_q + TW'(1);
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      par_d        = par_q;
      perr_d       = perr_q;
      data_d       = data_q;
      strobe_d     = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            // Edge detect, so a line stuck low cannot retrigger.
            if (rx_prev && !rx_s) begin
               state_d = STRT;
               par_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         STRT:
            // Start bit re-checked at its middle; a high line here was a glitch.
            if (timer_q == HALF_END) state_d = rx_s ? IDLE : DATA;
         DATA:
            // Timer restarted at mid start bit, so BIT_END lands on each data bit middle.
            if (timer_q == BIT_END) begin
               shreg_d = {rx_s, shreg_q[7:1]};
               par_d   = par_q ^ rx_s;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = PARITY;
            end
         PARITY:
            // Odd parity: the expected bit is the inverse of the data XOR.
            if (timer_q == BIT_END) begin
               perr_d  = rx_s != ~par_q;
               state_d = STP;
            end
         STP:
            if (timer_q == BIT_END) begin
               data_d       = shreg_q;
               parity_err_d = perr_q;
               frame_err_d  = ~rx_s;
               strobe_d     = 1'b1;
               state_d      = IDLE;
            end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) timer_d = '0;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         shreg_q      <= '0;
         cnt_q        <= '0;
         par_q        <= 1'b0;
         perr_q       <= 1'b0;
         data_q       <= '0;
         strobe_q     <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         par_q        <= par_d;
         perr_q       <= perr_d;
         data_q       <= data_d;
         strobe_q     <= strobe_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end

   assign data_rx     = data_q;
   assign data_strobe = strobe_q;
   assign parity_err  = parity_err_q;
   assign frame_err   = frame_err_q;
   assign rx_busy     = state_q != IDLE;

endmodule

// File: tb/tb_receiver_core.sv
// tb_receiver_core: directed and random UART frames against a frame-level model of the receiver
module tb_receiver_core;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         t;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data_rx;
   logic       data_strobe, parity_err, frame_err, rx_busy;

   int   cyc = 0;
   int   busy_cnt = 0;
   int   total = 0;
   int   bad = 0;
   rec_t got_q[$];
   rec_t exp_q[$];

   receiver_core #(.CLK_RATE(160), .BAUD_RATE(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .data_rx     (data_rx),
      .data_strobe (data_strobe),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_busy) busy_cnt <= busy_cnt + 1;
      if (data_strobe) got_q.push_back('{data_rx, parity_err, frame_err, cyc});
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One bit time is 16 clocks; rx changes 1 time unit after a rising edge.
   task automatic put_bit(input logic b);
      rx = b;
      repeat (16) @(posedge clk);
      #1;
   endtask

   // The stop-bit middle is 10.5 bit times after the start edge, plus 3 clocks of
   // synchronizer and edge-detect delay: 168 + 3 clocks.
   task automatic send(input logic [7:0] d, input logic p, input logic s);
      exp_q.push_back('{d, p != ~^d, ~s, cyc + 171});
      put_bit(1'b0);
      for (int i = 0; i < 8; i++) put_bit(d[i]);
      put_bit(p);
      put_bit(s);
   endtask

   task automatic drain(input string tag);
      rec_t g, e;
      repeat (64) @(posedge clk);
      #1;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_data"}, g.d, e.d);
         check({tag, "_perr"}, g.pe, e.pe);
         check({tag, "_ferr"}, g.fe, e.fe);
         check({tag, "_time"}, g.t, e.t);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] d;
      logic       p, s;
      int         b0, gap;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", data_rx, 0);
      check("rst_strobe", data_strobe, 0);
      check("rst_perr", parity_err, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_busy", rx_busy, 0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      send(8'hA5, 1'b1, 1'b1);
      put_bit(1'b1);
      drain("a5");

      send(8'h01, 1'b1, 1'b1);
      put_bit(1'b1);
      drain("perr01");

      d = 8'h3C;
      send(d, ~^d, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      check("low_hold_busy", rx_busy, 0);
      drain("ferr3c");
      check("sticky_ferr", frame_err, 1);
      put_bit(1'b1);
      d = 8'h81;
      send(d, ~^d, 1'b1);
      put_bit(1'b1);
      drain("after_ferr");

      b0 = busy_cnt;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("glitch_busy", busy_cnt - b0, 8);
      drain("glitch");

      d = 8'h55;
      send(d, ~^d, 1'b1);
      d = 8'hFF;
      send(d, ~^d, 1'b1);
      put_bit(1'b1);
      drain("b2b");

      d = 8'h12;
      put_bit(1'b0);
      for (int i = 0; i < 3; i++) put_bit(d[i]);
      rx = d[3];
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_data", data_rx, 0);
      check("mid_rst_strobe", data_strobe, 0);
      check("mid_rst_perr", parity_err, 0);
      check("mid_rst_ferr", frame_err, 0);
      check("mid_rst_busy", rx_busy, 0);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      put_bit(1'b1);
      d = 8'h34;
      send(d, ~^d, 1'b1);
      put_bit(1'b1);
      drain("post_rst");

      for (int n = 0; n < 150; n++) begin
         d = 8'($urandom);
         p = ~^d ^ ($urandom_range(0, 7) == 0);
         s = $urandom_range(0, 9) != 0;
         send(d, p, s);
         gap = s ? $urandom_range(0, 2) : $urandom_range(1, 2);
         repeat (gap) put_bit(1'b1);
      end
      put_bit(1'b1);
      drain("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
